// File: rtl/ddr3_pattern_tester.sv
// DDR3 self-test master on the Avalon-MM user port of the memory controller.
// A start writes LEN words of the selected pattern from BASE, reads them back
// with up to MAX_OUTSTANDING reads in flight, and compares each returned word
// against an independently regenerated pattern.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_WRITE | issuing pattern writes, one word per accepted request
// S_READ  | issuing reads while the in-flight count is below the limit
// S_DRAIN | all reads issued, waiting for the remaining read data/compares
// S_DONE  | results valid; a new start restarts the test
module ddr3_pattern_tester #(
  parameter int DATA_WIDTH      = 256,
  parameter int ADDR_WIDTH      = 22,
  parameter int LEN_WIDTH       = 22,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ERR_WIDTH       = 32
) (
  input  logic                      usr_clk,
  input  logic                      usr_rst,
  input  logic                      start_in,
  input  logic [1:0]                mode_in,
  input  logic [ADDR_WIDTH-1:0]     base_addr_in,
  input  logic [LEN_WIDTH-1:0]      len_in,
  output logic [ADDR_WIDTH-1:0]     ddr3_addr_o,
  output logic                      ddr3_write_o,
  output logic                      ddr3_read_o,
  output logic [DATA_WIDTH/8-1:0]   ddr3_byte_enable_o,
  output logic [DATA_WIDTH-1:0]     ddr3_write_data_o,
  input  logic                      ddr3_waitrequest_in,
  input  logic [DATA_WIDTH-1:0]     ddr3_rddata_in,
  input  logic                      ddr3_rddata_valid_in,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [ERR_WIDTH-1:0]      err_count_o,
  output logic [ADDR_WIDTH-1:0]     first_err_addr_o
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  typedef logic [LANES-1:0][31:0] lfsr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic lfsr_t lfsr_seed();
    lfsr_t s;
    for (int k = 0; k < LANES; k++) s[k] = LFSR_SEED ^ 32'(k);
    return s;
  endfunction

  function automatic lfsr_t lfsr_step(input lfsr_t s);
    lfsr_t n;
    for (int k = 0; k < LANES; k++)
      n[k] = (s[k] >> 1) ^ (s[k][0] ? LFSR_POLY : 32'h0);
    return n;
  endfunction

  // lane0 holds word_index*LANES, so lane k of the incrementing pattern is lane0+k
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]            mode,
                                                    input logic [31:0]           lane0,
                                                    input logic [DATA_WIDTH-1:0] onehot,
                                                    input lfsr_t                 lfsr);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    case (mode)
      2'd0:    for (int k = 0; k < LANES; k++) w[k*32 +: 32] = lane0 + 32'(k);
      2'd1:    for (int k = 0; k < LANES; k++) w[k*32 +: 32] = ~(lane0 + 32'(k));
      2'd2:    w = onehot;
      default: w = lfsr;
    endcase
    return w;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [1:0]            r_mode;
  logic [LEN_WIDTH-1:0]  r_wr_idx;
  logic [LEN_WIDTH-1:0]  r_rd_idx;
  logic [LEN_WIDTH-1:0]  r_cmp_idx;
  logic [31:0]           r_wr_lane0;
  logic [31:0]           r_cmp_lane0;
  logic [DATA_WIDTH-1:0] r_wr_onehot;
  logic [DATA_WIDTH-1:0] r_cmp_onehot;
  lfsr_t                 r_wr_lfsr;
  lfsr_t                 r_cmp_lfsr;
  logic [OW-1:0]         r_outstanding;
  logic                  r_cmp_valid;
  logic [DATA_WIDTH-1:0] r_cmp_data;
  logic [DATA_WIDTH-1:0] r_cmp_exp;
  logic [ADDR_WIDTH-1:0] r_cmp_addr;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  r_first_err_seen;

  logic                  w_start;
  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_rd_take;
  logic [LEN_WIDTH-1:0]  w_len_m1;
  logic                  w_last_wr;
  logic                  w_last_rd;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_wr_pat;
  logic [DATA_WIDTH-1:0] w_cmp_pat;
  logic                  w_done;

  assign w_start     = start_in && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_wr_req    = (r_state == S_WRITE);
  assign w_rd_req    = (r_state == S_READ) && (r_outstanding < OW'(MAX_OUTSTANDING));
  assign w_wr_accept = w_wr_req && !ddr3_waitrequest_in;
  assign w_rd_accept = w_rd_req && !ddr3_waitrequest_in;
  // read data arriving with nothing in flight is stray and dropped
  assign w_rd_take   = ddr3_rddata_valid_in && (r_outstanding != '0);
  assign w_len_m1    = r_len - LEN_WIDTH'(1);
  assign w_last_wr   = (r_wr_idx == w_len_m1);
  assign w_last_rd   = (r_rd_idx == w_len_m1);
  assign w_wr_addr   = r_base + ADDR_WIDTH'(r_wr_idx);
  assign w_rd_addr   = r_base + ADDR_WIDTH'(r_rd_idx);
  assign w_wr_pat    = pattern(r_mode, r_wr_lane0, r_wr_onehot, r_wr_lfsr);
  assign w_cmp_pat   = pattern(r_mode, r_cmp_lane0, r_cmp_onehot, r_cmp_lfsr);
  assign w_done      = (r_state == S_DONE);

  assign ddr3_write_o       = w_wr_req;
  assign ddr3_read_o        = w_rd_req;
  assign ddr3_addr_o        = w_wr_req ? w_wr_addr : (w_rd_req ? w_rd_addr : '0);
  assign ddr3_write_data_o  = w_wr_req ? w_wr_pat : '0;
  assign ddr3_byte_enable_o = (w_wr_req || w_rd_req) ? '1 : '0;
  assign busy_o             = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
  assign done_o             = w_done;
  assign pass_o             = w_done && (r_err_count == '0);
  assign err_count_o        = r_err_count;
  assign first_err_addr_o   = r_first_err_addr;

  // state register
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state logic; DRAIN also waits out the pending registered compare
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_in) w_state_nxt = (len_in == '0) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        if (!ddr3_waitrequest_in && w_last_wr) w_state_nxt = S_READ;
      end
      S_READ: begin
        if (w_rd_req && !ddr3_waitrequest_in && w_last_rd) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_outstanding == '0) && !r_cmp_valid) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // test parameters latched at start, plus write/read issue indices
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_base   <= '0;
      r_len    <= '0;
      r_mode   <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else if (w_start) begin
      r_base   <= base_addr_in;
      r_len    <= len_in;
      r_mode   <= mode_in;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else begin
      if (w_wr_accept) r_wr_idx <= r_wr_idx + LEN_WIDTH'(1);
      if (w_rd_accept) r_rd_idx <= r_rd_idx + LEN_WIDTH'(1);
    end
  end

  // write-side pattern generator, one step per accepted write
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_wr_lane0  <= '0;
      r_wr_onehot <= DATA_WIDTH'(1);
      r_wr_lfsr   <= lfsr_seed();
    end else if (w_start) begin
      r_wr_lane0  <= '0;
      r_wr_onehot <= DATA_WIDTH'(1);
      r_wr_lfsr   <= lfsr_seed();
    end else if (w_wr_accept) begin
      r_wr_lane0  <= r_wr_lane0 + 32'(LANES);
      r_wr_onehot <= {r_wr_onehot[DATA_WIDTH-2:0], r_wr_onehot[DATA_WIDTH-1]};
      r_wr_lfsr   <= lfsr_step(r_wr_lfsr);
    end
  end

  // compare-side generator: restarts on READ entry, steps on each returned word
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_cmp_idx    <= '0;
      r_cmp_lane0  <= '0;
      r_cmp_onehot <= DATA_WIDTH'(1);
      r_cmp_lfsr   <= lfsr_seed();
    end else if (w_wr_accept && w_last_wr) begin
      r_cmp_idx    <= '0;
      r_cmp_lane0  <= '0;
      r_cmp_onehot <= DATA_WIDTH'(1);
      r_cmp_lfsr   <= lfsr_seed();
    end else if (w_rd_take) begin
      r_cmp_idx    <= r_cmp_idx + LEN_WIDTH'(1);
      r_cmp_lane0  <= r_cmp_lane0 + 32'(LANES);
      r_cmp_onehot <= {r_cmp_onehot[DATA_WIDTH-2:0], r_cmp_onehot[DATA_WIDTH-1]};
      r_cmp_lfsr   <= lfsr_step(r_cmp_lfsr);
    end
  end

  // capture returned word with its expected value and address for the compare stage
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_cmp_valid <= 1'b0;
      r_cmp_data  <= '0;
      r_cmp_exp   <= '0;
      r_cmp_addr  <= '0;
    end else begin
      r_cmp_valid <= w_rd_take;
      if (w_rd_take) begin
        r_cmp_data <= ddr3_rddata_in;
        r_cmp_exp  <= w_cmp_pat;
        r_cmp_addr <= r_base + ADDR_WIDTH'(r_cmp_idx);
      end
    end
  end

  // reads in flight: issued but data not yet returned
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_accept, w_rd_take})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // saturating error count and first failing address
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_first_err_seen <= 1'b0;
    end else if (w_start) begin
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_first_err_seen <= 1'b0;
    end else if (r_cmp_valid && (r_cmp_data != r_cmp_exp)) begin
      if (r_err_count != '1) r_err_count <= r_err_count + ERR_WIDTH'(1);
      if (!r_first_err_seen) begin
        r_first_err_addr <= r_cmp_addr;
        r_first_err_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_pattern_tester.sv
// Bench for ddr3_pattern_tester: a behavioural Avalon memory with configurable
// read latency, random stalls and an optional stuck bit, plus a pattern model
// computed per word index from the pattern definitions.
module tb_ddr3_pattern_tester;

  localparam int DW = 256;
  localparam int AW = 22;
  localparam int LW = 22;
  localparam int MO = 16;
  localparam int EW = 32;
  localparam int LANES = DW / 32;

  logic          usr_clk = 1'b0;
  logic          usr_rst;
  logic          start_in;
  logic [1:0]    mode_in;
  logic [AW-1:0] base_addr_in;
  logic [LW-1:0] len_in;
  logic [AW-1:0] ddr3_addr_o;
  logic          ddr3_write_o;
  logic          ddr3_read_o;
  logic [DW/8-1:0] ddr3_byte_enable_o;
  logic [DW-1:0] ddr3_write_data_o;
  logic          ddr3_waitrequest_in;
  logic [DW-1:0] ddr3_rddata_in;
  logic          ddr3_rddata_valid_in;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic [EW-1:0] err_count_o;
  logic [AW-1:0] first_err_addr_o;

  ddr3_pattern_tester #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO), .ERR_WIDTH(EW)
  ) dut (
    .usr_clk(usr_clk), .usr_rst(usr_rst), .start_in(start_in), .mode_in(mode_in),
    .base_addr_in(base_addr_in), .len_in(len_in), .ddr3_addr_o(ddr3_addr_o),
    .ddr3_write_o(ddr3_write_o), .ddr3_read_o(ddr3_read_o),
    .ddr3_byte_enable_o(ddr3_byte_enable_o), .ddr3_write_data_o(ddr3_write_data_o),
    .ddr3_waitrequest_in(ddr3_waitrequest_in), .ddr3_rddata_in(ddr3_rddata_in),
    .ddr3_rddata_valid_in(ddr3_rddata_valid_in), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o)
  );

  always #5 usr_clk = ~usr_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // test configuration shared with the memory model
  int            t_base     = 0;
  int            t_lat      = 1;
  int            t_wait_pct = 0;
  bit            t_flip     = 1'b0;
  bit            spur       = 1'b0;
  logic [DW-1:0] exp_q[$];

  // memory model bookkeeping
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rd_t;
  rd_t           rq[$];
  rd_t           rq_head;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] rb_tmp;
  int cyc = 0, wr_seen = 0, rd_seen = 0, wr_err = 0, rd_err = 0;
  int stab_err = 0, be_err = 0, ovf_err = 0, tb_out = 0, max_out = 0;
  bit            prev_stall = 1'b0;
  logic          prev_wr, prev_rd;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // expected word i for each mode, built directly from the pattern definitions
  task automatic build_exp(input logic [1:0] mode, input int len);
    logic [31:0]   lf [LANES];
    logic [DW-1:0] w;
    exp_q.delete();
    for (int k = 0; k < LANES; k++) lf[k] = 32'hACE1_0001 ^ 32'(k);
    for (int i = 0; i < len; i++) begin
      w = '0;
      for (int k = 0; k < LANES; k++) begin
        case (mode)
          2'd0: w[k*32 +: 32] = 32'(i * LANES + k);
          2'd1: w[k*32 +: 32] = ~32'(i * LANES + k);
          2'd3: w[k*32 +: 32] = lf[k];
          default: ;
        endcase
        lf[k] = lfsr_next(lf[k]);
      end
      if (mode == 2'd2) w[i % DW] = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  // Avalon memory: stalls, latency, in-order returns, protocol checks
  always @(negedge usr_clk) begin
    cyc++;
    if (usr_rst) begin
      rq.delete();
      tb_out = 0;
      prev_stall = 1'b0;
      ddr3_waitrequest_in = 1'b0;
      ddr3_rddata_valid_in = 1'b0;
      ddr3_rddata_in = '0;
    end else begin
      if (prev_stall && (ddr3_write_o !== prev_wr || ddr3_read_o !== prev_rd ||
                         ddr3_addr_o !== prev_addr || ddr3_write_data_o !== prev_data))
        stab_err++;
      if (ddr3_byte_enable_o !== ((ddr3_write_o || ddr3_read_o) ? {(DW/8){1'b1}} : {(DW/8){1'b0}}))
        be_err++;
      if (ddr3_read_o && tb_out >= MO) ovf_err++;
      ddr3_waitrequest_in = ($urandom_range(99) < t_wait_pct);
      ddr3_rddata_valid_in = 1'b0;
      ddr3_rddata_in = '0;
      if (spur) begin
        ddr3_rddata_valid_in = 1'b1;
        ddr3_rddata_in = {8{$urandom}};
        spur = 1'b0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        rq_head = rq.pop_front();
        rb_tmp = mem.exists(rq_head.addr) ? mem[rq_head.addr] : '0;
        if (t_flip && rq_head.addr == AW'(16)) rb_tmp[5] = ~rb_tmp[5];
        ddr3_rddata_in = rb_tmp;
        ddr3_rddata_valid_in = 1'b1;
        tb_out--;
      end
      if (!ddr3_waitrequest_in) begin
        if (ddr3_write_o) begin
          if (wr_seen >= exp_q.size() || ddr3_addr_o !== AW'(t_base + wr_seen) ||
              ddr3_write_data_o !== exp_q[wr_seen])
            wr_err++;
          mem[ddr3_addr_o] = ddr3_write_data_o;
          wr_seen++;
        end
        if (ddr3_read_o) begin
          if (ddr3_addr_o !== AW'(t_base + rd_seen)) rd_err++;
          rq.push_back('{addr: ddr3_addr_o, due: cyc + t_lat});
          tb_out++;
          if (tb_out > max_out) max_out = tb_out;
          rd_seen++;
        end
      end
      prev_stall = (ddr3_write_o || ddr3_read_o) && ddr3_waitrequest_in;
      prev_wr    = ddr3_write_o;
      prev_rd    = ddr3_read_o;
      prev_addr  = ddr3_addr_o;
      prev_data  = ddr3_write_data_o;
    end
  end

  task automatic run_test(input string tag, input logic [1:0] mode, input int base, input int len,
                          input int lat, input int wpct, input bit flip);
    int            exp_err;
    int            exp_first;
    int            cnt;
    logic [AW-1:0] a;
    logic [DW-1:0] rb;
    build_exp(mode, len);
    exp_err = 0;
    exp_first = 0;
    for (int i = 0; i < len; i++) begin
      a  = AW'(base + i);
      rb = exp_q[i];
      if (flip && a == AW'(16)) rb[5] = ~rb[5];
      if (rb !== exp_q[i]) begin
        if (exp_err == 0) exp_first = int'(a);
        exp_err++;
      end
    end
    @(negedge usr_clk);
    t_base = base; t_lat = lat; t_wait_pct = wpct; t_flip = flip;
    wr_seen = 0; rd_seen = 0; wr_err = 0; rd_err = 0;
    stab_err = 0; be_err = 0; ovf_err = 0; max_out = 0;
    mode_in = mode; base_addr_in = AW'(base); len_in = LW'(len); start_in = 1'b1;
    @(negedge usr_clk);
    start_in = 1'b0;
    if (len != 0) begin
      check({tag, ":busy_after_start"}, 64'(busy_o), 64'd1);
      check({tag, ":done_cleared"}, 64'(done_o), 64'd0);
    end
    cnt = 0;
    while (!done_o && cnt < 20000) begin
      @(negedge usr_clk);
      cnt++;
    end
    check({tag, ":done"}, 64'(done_o), 64'd1);
    check({tag, ":busy_end"}, 64'(busy_o), 64'd0);
    check({tag, ":err_count"}, 64'(err_count_o), 64'(exp_err));
    check({tag, ":first_err"}, 64'(first_err_addr_o), 64'(exp_first));
    check({tag, ":pass"}, 64'(pass_o), 64'(exp_err == 0));
    check({tag, ":n_writes"}, 64'(wr_seen), 64'(len));
    check({tag, ":n_reads"}, 64'(rd_seen), 64'(len));
    check({tag, ":write_content"}, 64'(wr_err), 64'd0);
    check({tag, ":read_addr"}, 64'(rd_err), 64'd0);
    check({tag, ":stable_stall"}, 64'(stab_err), 64'd0);
    check({tag, ":byte_enable"}, 64'(be_err), 64'd0);
    check({tag, ":outstanding_limit"}, 64'(ovf_err), 64'd0);
    check({tag, ":drained"}, 64'(tb_out), 64'd0);
  endtask

  initial begin
    int cnt;
    usr_rst = 1'b1;
    start_in = 1'b0;
    mode_in = '0;
    base_addr_in = '0;
    len_in = '0;
    repeat (3) @(negedge usr_clk);
    check("rst:write", 64'(ddr3_write_o), 64'd0);
    check("rst:read", 64'(ddr3_read_o), 64'd0);
    check("rst:addr", 64'(ddr3_addr_o), 64'd0);
    check("rst:be", 64'(ddr3_byte_enable_o), 64'd0);
    check("rst:wdata_nz", 64'(ddr3_write_data_o != '0), 64'd0);
    check("rst:busy", 64'(busy_o), 64'd0);
    check("rst:done", 64'(done_o), 64'd0);
    check("rst:pass", 64'(pass_o), 64'd0);
    check("rst:err", 64'(err_count_o), 64'd0);
    check("rst:first", 64'(first_err_addr_o), 64'd0);
    usr_rst = 1'b0;
    @(negedge usr_clk);
    spur = 1'b1;
    repeat (2) @(negedge usr_clk);

    run_test("m0_len8", 2'd0, 0, 8, 2, 0, 1'b0);
    run_test("m1_wrap", 2'd1, (1 << AW) - 2, 4, 3, 0, 1'b0);
    run_test("m3_stall", 2'd3, 1000, 64, 4, 30, 1'b0);
    run_test("m2_flip", 2'd2, 0, 32, 2, 0, 1'b1);
    run_test("lat40", 2'd0, 500, 100, 40, 0, 1'b0);
    check("lat40:max_outstanding", 64'(max_out), 64'(MO));
    run_test("len0", 2'd0, 77, 0, 1, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      bit fl;
      fl = ($urandom_range(1) == 1);
      run_test($sformatf("rand%0d", r), 2'($urandom_range(3)),
               fl ? int'($urandom_range(16)) : int'($urandom_range((1 << AW) - 1)),
               int'($urandom_range(40, 1)), int'($urandom_range(10, 1)),
               int'($urandom_range(50)), fl);
    end

    // reset while reads are in flight
    t_base = 300; t_lat = 20; t_wait_pct = 0; t_flip = 1'b0;
    build_exp(2'd0, 50);
    wr_seen = 0; rd_seen = 0;
    @(negedge usr_clk);
    mode_in = 2'd0; base_addr_in = AW'(300); len_in = LW'(50); start_in = 1'b1;
    @(negedge usr_clk);
    start_in = 1'b0;
    cnt = 0;
    while (!ddr3_read_o && cnt < 2000) begin
      @(negedge usr_clk);
      cnt++;
    end
    repeat (5) @(negedge usr_clk);
    check("midrst:in_read", 64'(ddr3_read_o), 64'd1);
    #2 usr_rst = 1'b1;
    #1;
    check("midrst:write", 64'(ddr3_write_o), 64'd0);
    check("midrst:read", 64'(ddr3_read_o), 64'd0);
    check("midrst:addr", 64'(ddr3_addr_o), 64'd0);
    check("midrst:be", 64'(ddr3_byte_enable_o), 64'd0);
    check("midrst:busy", 64'(busy_o), 64'd0);
    check("midrst:done", 64'(done_o), 64'd0);
    check("midrst:err", 64'(err_count_o), 64'd0);
    @(negedge usr_clk);
    usr_rst = 1'b0;
    repeat (3) @(negedge usr_clk);
    check("midrst:stay_idle_busy", 64'(busy_o), 64'd0);
    check("midrst:stay_idle_read", 64'(ddr3_read_o), 64'd0);
    check("midrst:stay_idle_done", 64'(done_o), 64'd0);
    run_test("after_rst", 2'd3, 40, 20, 3, 20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
